// File: rtl/spi_ram_pkg.sv
// Shared types and sizes for the SPI RAM master, its bench and scoreboard.
package spi_ram_pkg;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_W     = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_CMD,
        ST_SHIFT,
        ST_WAIT,
        ST_CAPT,
        ST_GAP
    } state_e;

endpackage

// File: rtl/spi_ram_master.sv
// SPI master that serialises one RAM command per frame onto SS_n/MOSI
// and returns read-data bytes captured from MISO on a one-cycle strobe.
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned GAP     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] CAPT_LOAD  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP - 1);

    state_e                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [FRAME_BITS-1:0] sr, sr_d;
    logic                  rd_q, rd_d;
    logic [DATA_W-2:0]     cap, cap_d;
    logic [DATA_W-1:0]     rsp_data_d;
    logic                  rsp_valid_d;
    logic                  ss_n_d;
    logic                  mosi_d;
    logic                  busy_d;
    logic                  cmd_is_rd;

    assign cmd_ready = (state == ST_IDLE);
    assign cmd_is_rd = (cmd_op == RD_DATA);

    // Next-state, shared down-counter and datapath; every counted state reloads on entry.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        sr_d        = sr;
        rd_d        = rd_q;
        cap_d       = cap;
        rsp_data_d  = rsp_data;
        rsp_valid_d = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_SEL;
                    sr_d    = {cmd_op, cmd_is_rd ? {DATA_W{1'b0}} : cmd_data};
                    rd_d    = cmd_is_rd;
                end
            end
            ST_SEL: state_d = ST_CMD;
            ST_CMD: begin
                state_d = ST_SHIFT;
                cnt_d   = SHIFT_LOAD;
            end
            ST_SHIFT: begin
                sr_d = {sr[FRAME_BITS-2:0], 1'b0};
                if (cnt == '0) begin
                    state_d = rd_q ? ST_WAIT : ST_GAP;
                    cnt_d   = rd_q ? WAIT_LOAD : GAP_LOAD;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_d = ST_CAPT;
                    cnt_d   = CAPT_LOAD;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_CAPT: begin
                cap_d = {cap[DATA_W-3:0], MISO};
                if (cnt == '0) begin
                    rsp_data_d  = {cap, MISO};
                    rsp_valid_d = 1'b1;
                    state_d     = ST_GAP;
                    cnt_d       = GAP_LOAD;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin values are decoded from the next state so the flops line up with the state they belong to.
        ss_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
        mosi_d = ((state_d == ST_CMD) || (state_d == ST_SHIFT)) && sr_d[FRAME_BITS-1];
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sr        <= '0;
            rd_q      <= 1'b0;
            cap       <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sr        <= sr_d;
            rd_q      <= rd_d;
            cap       <= cap_d;
            rsp_data  <= rsp_data_d;
            rsp_valid <= rsp_valid_d;
            SS_n      <= ss_n_d;
            MOSI      <= mosi_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: behavioural SPI-slave/RAM on the pins plus a
// command-level RAM reference model for responses, frame shapes and pacing.
module tb_spi_ram_master;
    import spi_ram_pkg::*;

    parameter int RD_WAIT = 2;
    parameter int GAP     = 1;

    localparam int WR_LEN = 12;
    localparam int RD_LEN = 20 + RD_WAIT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b0;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    spi_ram_master #(.RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seed(int i);
        return 8'((i * 29) ^ 8'h5A);
    endfunction

    // ---------------- pin-level slave/RAM and recorders ----------------
    logic [7:0]  ram [256];
    bit          ram_init = 1'b0;
    logic [7:0]  s_wa = 8'h00, s_ra = 8'h00, s_rd_byte = 8'h00;
    logic [11:0] hdr = '0;
    int          fc = 0, hc = 0;
    bit          seen = 1'b0;
    logic        prev_ss = 1'b1;
    int          ready_viol = 0, busy_viol = 0;
    int          frame_len_q[$];
    logic [11:0] frame_hdr_q[$];
    int          gap_q[$];
    logic [7:0]  rsp_q[$];
    bit          rsp_gap_q[$];
    int          acc_q[$];
    int          pcyc = 0;

    always @(negedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] = seed(i);
            ram_init = 1'b1;
        end
        if (rsp_valid) begin
            rsp_q.push_back(rsp_data);
            rsp_gap_q.push_back(SS_n && !prev_ss);
        end
        if (!SS_n) begin
            if (cmd_ready) ready_viol++;
            if (!busy) busy_viol++;
            if (fc == 0) begin
                if (seen) gap_q.push_back(hc);
                s_rd_byte = ram[s_ra];
            end
            if (fc < 12) hdr = {hdr[10:0], MOSI};
            if (fc >= 12 + RD_WAIT && fc < RD_LEN) MISO = s_rd_byte[7 - (fc - 12 - RD_WAIT)];
            else MISO = 1'($urandom);
            fc++;
        end else begin
            MISO = 1'($urandom);
            if (fc > 0) begin
                frame_len_q.push_back(fc);
                frame_hdr_q.push_back(hdr);
                if (fc == WR_LEN || fc == RD_LEN) begin
                    case (hdr[9:8])
                        2'b00:   s_wa = hdr[7:0];
                        2'b01:   ram[s_wa] = hdr[7:0];
                        2'b10:   s_ra = hdr[7:0];
                        default: ;
                    endcase
                end
                seen = 1'b1;
                fc = 0;
                hc = 0;
            end
            hc++;
        end
        prev_ss = SS_n;
    end

    always @(posedge clk) begin
        pcyc++;
        if (rst_n && cmd_valid && cmd_ready) acc_q.push_back(pcyc);
    end

    // ---------------- command-level reference model ----------------
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_wa = 8'h00, ref_ra = 8'h00;
    int          exp_len_q[$];
    logic [11:0] exp_hdr_q[$];
    logic [7:0]  exp_rsp_q[$];
    logic [1:0]  q_op[$];
    logic [7:0]  q_data[$];

    function automatic void ref_apply(input logic [1:0] op, input logic [7:0] d);
        exp_len_q.push_back(op == 2'b11 ? RD_LEN : WR_LEN);
        exp_hdr_q.push_back({1'b0, op[1], op, (op == 2'b11) ? 8'h00 : d});
        case (op)
            2'b00:   ref_wa = d;
            2'b01:   ref_mem[ref_wa] = d;
            2'b10:   ref_ra = d;
            default: exp_rsp_q.push_back(ref_mem[ref_ra]);
        endcase
    endfunction

    function automatic void clear_exp();
        exp_len_q.delete();
        exp_hdr_q.delete();
        exp_rsp_q.delete();
    endfunction

    task automatic drive_stream(input bit hold);
        int n;
        while (q_op.size() > 0) begin
            cmd_op    = q_op.pop_front();
            cmd_data  = q_data.pop_front();
            cmd_valid = 1'b1;
            ref_apply(cmd_op, cmd_data);
            n = 0;
            while (!cmd_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!cmd_ready) begin fails++; $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n); end
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(cmd_ready && !busy && SS_n) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(cmd_ready && !busy)) begin fails++; $display("FAIL idle_timeout: ready=%0b busy=%0b, required 1/0", cmd_ready, busy); end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (SS_n !== 1'b1) begin fails++; $display("FAIL reset_ss_n: got %0b, required 1", SS_n); end
            checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %0b, required 1", cmd_ready); end
            checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %0b, required 0", rsp_valid); end
            checks++; if (rsp_data !== 8'h00) begin fails++; $display("FAIL reset_rsp_data: got %h, required 00", rsp_data); end
            checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b, required 0", busy); end
            checks++; if (MOSI !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %0b, required 0", MOSI); end
        end
    endtask

    task automatic test_write_addr();
        int fb = frame_len_q.size();
        clear_exp();
        q_op.push_back(2'b00); q_data.push_back(8'h3C);
        drive_stream(1'b0);
        wait_idle();
        checks++;
        if (frame_len_q.size() !== fb + 1) begin
            fails++; $display("FAIL wa_frames: got %0d, required 1", frame_len_q.size() - fb);
        end else begin
            checks++; if (frame_len_q[fb] !== WR_LEN) begin fails++; $display("FAIL wa_len: got %0d, required %0d", frame_len_q[fb], WR_LEN); end
            checks++; if (frame_hdr_q[fb] !== 12'b0000_0011_1100) begin fails++; $display("FAIL wa_mosi: got %b, required 000000111100", frame_hdr_q[fb]); end
        end
        checks++; if (s_wa !== 8'h3C) begin fails++; $display("FAIL wa_slave_addr: got %h, required 3c", s_wa); end
    endtask

    task automatic test_readback();
        int fb = frame_len_q.size();
        int rb = rsp_q.size();
        clear_exp();
        q_op.push_back(2'b00); q_data.push_back(8'h3C);
        q_op.push_back(2'b01); q_data.push_back(8'hA5);
        q_op.push_back(2'b10); q_data.push_back(8'h3C);
        q_op.push_back(2'b11); q_data.push_back(8'hFF);
        drive_stream(1'b0);
        wait_idle();
        checks++;
        if (rsp_q.size() !== rb + 1) begin
            fails++; $display("FAIL rb_pulses: got %0d, required 1", rsp_q.size() - rb);
        end else begin
            checks++; if (rsp_q[rb] !== 8'hA5) begin fails++; $display("FAIL rb_data: got %h, required a5", rsp_q[rb]); end
            checks++; if (rsp_gap_q[rb] !== 1'b1) begin fails++; $display("FAIL rb_strobe_slot: got %0b, required 1", rsp_gap_q[rb]); end
        end
        checks++;
        if (frame_len_q.size() !== fb + 4) begin
            fails++; $display("FAIL rb_frames: got %0d, required 4", frame_len_q.size() - fb);
        end else begin
            checks++; if (frame_len_q[fb+3] !== RD_LEN) begin fails++; $display("FAIL rb_rd_len: got %0d, required %0d", frame_len_q[fb+3], RD_LEN); end
            checks++; if (frame_hdr_q[fb+3] !== 12'b0111_0000_0000) begin fails++; $display("FAIL rb_rd_mosi: got %b, required 011100000000", frame_hdr_q[fb+3]); end
        end
        checks++; if (rsp_data !== 8'hA5) begin fails++; $display("FAIL rb_hold: got %h, required a5", rsp_data); end
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rb_pulse_width: got %0b, required 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int ab = acc_q.size();
        int gb = gap_q.size();
        int fb = frame_len_q.size();
        int rv = ready_viol;
        int bv = busy_viol;
        clear_exp();
        for (int i = 0; i < 4; i++) begin
            q_op.push_back(2'(i % 2)); q_data.push_back(8'($urandom));
        end
        drive_stream(1'b1);
        wait_idle();
        checks++;
        if (acc_q.size() !== ab + 4 || gap_q.size() !== gb + 4 || frame_len_q.size() !== fb + 4) begin
            fails++; $display("FAIL b2b_counts: accepts=%0d gaps=%0d frames=%0d, required 4 each", acc_q.size() - ab, gap_q.size() - gb, frame_len_q.size() - fb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (frame_hdr_q[fb+i] !== exp_hdr_q[i]) begin fails++; $display("FAIL b2b_mosi[%0d]: got %b, required %b", i, frame_hdr_q[fb+i], exp_hdr_q[i]); end
                if (i > 0) begin
                    checks++; if (acc_q[ab+i] - acc_q[ab+i-1] !== WR_LEN + GAP + 1) begin fails++; $display("FAIL b2b_period[%0d]: got %0d, required %0d", i, acc_q[ab+i] - acc_q[ab+i-1], WR_LEN + GAP + 1); end
                    checks++; if (gap_q[gb+i] !== GAP + 1) begin fails++; $display("FAIL b2b_ss_high[%0d]: got %0d, required %0d", i, gap_q[gb+i], GAP + 1); end
                end
            end
        end
        checks++; if (ready_viol !== rv) begin fails++; $display("FAIL b2b_ready_in_frame: got %0d cycles, required 0", ready_viol - rv); end
        checks++; if (busy_viol !== bv) begin fails++; $display("FAIL b2b_busy_in_frame: got %0d idle cycles, required 0", busy_viol - bv); end
    endtask

    task automatic test_reset_mid_capt();
        int rb;
        int c = 12 + RD_WAIT + 4;
        clear_exp();
        q_op.push_back(2'b10); q_data.push_back(8'h3C);
        drive_stream(1'b0);
        wait_idle();
        rb = rsp_q.size();
        cmd_op = 2'b11; cmd_data = 8'h77; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (c + 1) @(posedge clk);
        #2;
        checks++; if (SS_n !== 1'b0) begin fails++; $display("FAIL abort_in_frame: SS_n got %0b, required 0", SS_n); end
        rst_n = 1'b0;
        #1;
        checks++; if (SS_n !== 1'b1) begin fails++; $display("FAIL abort_ss_n: got %0b, required 1", SS_n); end
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL abort_rsp_valid: got %0b, required 0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin fails++; $display("FAIL abort_rsp_data: got %h, required 00", rsp_data); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %0b, required 0", busy); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (rsp_q.size() !== rb) begin fails++; $display("FAIL abort_no_rsp: got %0d pulses, required 0", rsp_q.size() - rb); end
        checks++; if (rsp_data !== 8'h00) begin fails++; $display("FAIL abort_rsp_data_after: got %h, required 00", rsp_data); end
        clear_exp();
        q_op.push_back(2'b10); q_data.push_back(8'h3C);
        q_op.push_back(2'b11); q_data.push_back(8'h00);
        drive_stream(1'b1);
        wait_idle();
        checks++;
        if (rsp_q.size() !== rb + 1) begin
            fails++; $display("FAIL abort_reread_pulses: got %0d, required 1", rsp_q.size() - rb);
        end else begin
            checks++; if (rsp_q[rb] !== 8'hA5) begin fails++; $display("FAIL abort_reread_data: got %h, required a5", rsp_q[rb]); end
        end
    endtask

    task automatic test_random();
        int n  = 40;
        int ab = acc_q.size();
        int gb = gap_q.size();
        int fb = frame_len_q.size();
        int rb = rsp_q.size();
        int rv = ready_viol;
        logic [1:0] op;
        clear_exp();
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom_range(0, 3));
            q_op.push_back(op);
            q_data.push_back(op[0] ? 8'($urandom) : 8'($urandom_range(0, 7)));
        end
        drive_stream(1'b1);
        wait_idle();
        checks++;
        if (rsp_q.size() - rb !== exp_rsp_q.size()) begin
            fails++; $display("FAIL rnd_rsp_count: got %0d, required %0d", rsp_q.size() - rb, exp_rsp_q.size());
        end else begin
            foreach (exp_rsp_q[i]) begin
                checks++; if (rsp_q[rb+i] !== exp_rsp_q[i]) begin fails++; $display("FAIL rnd_rsp[%0d]: got %h, required %h", i, rsp_q[rb+i], exp_rsp_q[i]); end
                checks++; if (rsp_gap_q[rb+i] !== 1'b1) begin fails++; $display("FAIL rnd_rsp_slot[%0d]: got %0b, required 1", i, rsp_gap_q[rb+i]); end
            end
        end
        checks++;
        if (frame_len_q.size() !== fb + n || acc_q.size() !== ab + n || gap_q.size() !== gb + n) begin
            fails++; $display("FAIL rnd_counts: frames=%0d accepts=%0d gaps=%0d, required %0d each", frame_len_q.size() - fb, acc_q.size() - ab, gap_q.size() - gb, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++; if (frame_len_q[fb+i] !== exp_len_q[i]) begin fails++; $display("FAIL rnd_len[%0d]: got %0d, required %0d", i, frame_len_q[fb+i], exp_len_q[i]); end
                checks++; if (frame_hdr_q[fb+i] !== exp_hdr_q[i]) begin fails++; $display("FAIL rnd_mosi[%0d]: got %b, required %b", i, frame_hdr_q[fb+i], exp_hdr_q[i]); end
                if (i > 0) begin
                    checks++; if (acc_q[ab+i] - acc_q[ab+i-1] !== exp_len_q[i-1] + GAP + 1) begin fails++; $display("FAIL rnd_period[%0d]: got %0d, required %0d", i, acc_q[ab+i] - acc_q[ab+i-1], exp_len_q[i-1] + GAP + 1); end
                    checks++; if (gap_q[gb+i] !== GAP + 1) begin fails++; $display("FAIL rnd_ss_high[%0d]: got %0d, required %0d", i, gap_q[gb+i], GAP + 1); end
                end
            end
        end
        checks++; if (ready_viol !== rv) begin fails++; $display("FAIL rnd_ready_in_frame: got %0d cycles, required 0", ready_viol - rv); end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
        test_reset();
        test_write_addr();
        test_readback();
        test_back_to_back();
        test_reset_mid_capt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
